// File: rtl/asrv32_soc_pkg.sv
// Shared definitions for the asrv32 SoC UART transmitter: register map,
// STATUS bit positions, transmit FSM encoding and a divider helper.
package asrv32_soc_pkg;

    // Word offsets (addr[3:2]) inside the 16-byte UART window
    localparam logic [1:0] UART_OFF_TXDATA  = 2'd0;
    localparam logic [1:0] UART_OFF_STATUS  = 2'd1;
    localparam logic [1:0] UART_OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] UART_OFF_CTRL    = 2'd3;

    // STATUS register bit positions
    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 8;

    // STATUS write: this data bit clears the sticky overflow flag
    localparam int ST_OVF_CLR_BIT = 3;

    // Serial transmit FSM states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // A divider of zero would stall the baud counter, so it is promoted to 1
    function automatic logic [15:0] div_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/asrv32_sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A pop is honoured before a
// push in the same cycle, so a full FIFO can accept a byte while draining.
module asrv32_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok;
    logic             push_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/asrv32_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode and registers, a byte FIFO,
// and a baud-timed shifter that streams frames back-to-back while data waits.
module asrv32_uart_tx_mmio
    import asrv32_soc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_8000,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_in,
    input  logic [3:0]  i_wr_mask,
    input  logic        i_wr_en,
    input  logic        i_rd_en,
    output logic [31:0] o_data_out,
    output logic        o_ack,
    output logic        o_tx,
    output logic        o_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus side
    logic        hit;
    logic [1:0]  offset;
    logic        wr_hit;
    logic        rd_hit;
    logic        fifo_push;
    logic        ovf_clr;
    logic [31:0] rdata_d;
    logic [15:0] div_wr_d;

    logic        ack_q;
    logic [31:0] rdata_q;
    logic [15:0] div_q;
    logic        irq_en_q;
    logic        ovf_q;
    logic        irq_q;

    // FIFO side
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_pop;

    // Shifter side
    tx_state_e   state_q;
    logic [15:0] cnt_q;
    logic [15:0] frame_div_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_q;
    logic        tx_q;
    logic        busy;

    logic        unused_bits;
    assign unused_bits = ^{i_data_addr[1:0], i_data_in[31:16], i_wr_mask[3:2]};

    assign hit       = (i_data_addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = i_data_addr[3:2];
    assign wr_hit    = i_wr_en && hit;
    assign rd_hit    = i_rd_en && hit;
    assign fifo_push = wr_hit && (offset == UART_OFF_TXDATA) && i_wr_mask[0];
    assign ovf_clr   = wr_hit && (offset == UART_OFF_STATUS) && i_wr_mask[0]
                       && i_data_in[ST_OVF_CLR_BIT];
    assign busy      = (state_q != TX_IDLE);

    // The shifter takes the FIFO head when idle or right at the end of a stop bit
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == TX_IDLE) || ((state_q == TX_STOP) && (cnt_q == 16'd0)));

    assign o_ack      = ack_q;
    assign o_data_out = rdata_q;
    assign o_tx       = tx_q;
    assign o_irq      = irq_q;

    asrv32_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_data  (i_data_in[7:0]),
        .i_pop   (fifo_pop),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // Read mux sees current state, so a same-cycle write is not yet visible
    always_comb begin
        rdata_d = 32'd0;
        case (offset)
            UART_OFF_STATUS: begin
                rdata_d[ST_FULL]                = fifo_full;
                rdata_d[ST_EMPTY]               = fifo_empty;
                rdata_d[ST_BUSY]                = busy;
                rdata_d[ST_OVF]                 = ovf_q;
                rdata_d[ST_CNT_LO +: 8]         = 8'(fifo_count);
            end
            UART_OFF_BAUDDIV: rdata_d[15:0]     = div_q;
            UART_OFF_CTRL:    rdata_d[0]        = irq_en_q;
            default:          rdata_d           = 32'd0;
        endcase
    end

    // Byte-lane merge of a BAUDDIV store with the current divider
    always_comb begin
        div_wr_d = div_q;
        if (i_wr_mask[0]) div_wr_d[7:0]  = i_data_in[7:0];
        if (i_wr_mask[1]) div_wr_d[15:8] = i_data_in[15:8];
    end

    // Bus response, configuration registers, overflow flag and interrupt level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_q    <= 1'b0;
            rdata_q  <= 32'd0;
            div_q    <= BAUD_DIV_RST;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q   <= wr_hit || rd_hit;
            rdata_q <= rd_hit ? rdata_d : 32'd0;
            if (wr_hit && (offset == UART_OFF_BAUDDIV)) begin
                div_q <= div_sanitize(div_wr_d);
            end
            if (wr_hit && (offset == UART_OFF_CTRL) && i_wr_mask[0]) begin
                irq_en_q <= i_data_in[0];
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            irq_q <= fifo_empty && !busy && irq_en_q;
        end
    end

    // Frame FSM: every state lasts frame_div_q cycles, counted down to zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= TX_IDLE;
            cnt_q       <= 16'd0;
            frame_div_q <= 16'd1;
            shift_q     <= 8'd0;
            bit_q       <= 3'd0;
            tx_q        <= 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        state_q     <= TX_START;
                        shift_q     <= fifo_data;
                        frame_div_q <= div_q;
                        cnt_q       <= div_q - 16'd1;
                        tx_q        <= 1'b0;
                    end
                end
                TX_START: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= TX_DATA;
                        cnt_q   <= frame_div_q - 16'd1;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= frame_div_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (cnt_q == 16'd0) begin
                        if (!fifo_empty) begin
                            state_q     <= TX_START;
                            shift_q     <= fifo_data;
                            frame_div_q <= div_q;
                            cnt_q       <= div_q - 16'd1;
                            tx_q        <= 1'b0;
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asrv32_uart_tx_mmio.sv
// Scoreboard bench for the MMIO UART transmitter. Stimulus tasks compute the
// expected bus responses and serial frames from a frame schedule model and
// queue them; independent monitors compare what the DUT actually produces.
module tb_asrv32_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h0000_8000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  mask = 4'd0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] o_data_out;
    logic        o_ack;
    logic        o_tx;
    logic        o_irq;

    asrv32_uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .FIFO_DEPTH   (DEPTH),
        .BAUD_DIV_RST (16'd434)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data_addr (addr),
        .i_data_in   (wdata),
        .i_wr_mask   (mask),
        .i_wr_en     (wr_en),
        .i_rd_en     (rd_en),
        .o_data_out  (o_data_out),
        .o_ack       (o_ack),
        .o_tx        (o_tx),
        .o_irq       (o_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] b;
        int         arrival;
        int         start;
        int         div;
    } fr_t;

    typedef struct {
        int          cyc;
        logic        chk;
        logic [31:0] data;
        string       name;
    } ack_t;

    fr_t  sched[$];
    fr_t  rxq[$];
    ack_t ackq[$];

    int   model_div    = 434;
    logic model_ovf    = 1'b0;
    logic model_irq_en = 1'b0;
    int   last_end     = 0;

    // Bytes that have arrived in the FIFO but not yet started transmitting
    function automatic int model_count(input int r);
        int c = 0;
        foreach (sched[i]) if (sched[i].arrival <= r && sched[i].start > r) c++;
        return c;
    endfunction

    function automatic logic model_busy(input int r);
        foreach (sched[i])
            if (sched[i].start <= r && r < sched[i].start + 10 * sched[i].div) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_status(input int r);
        int         c  = model_count(r);
        logic [7:0] c8 = c[7:0];
        return {16'h0, c8, 4'h0, model_ovf, model_busy(r), (c == 0), (c == DEPTH)};
    endfunction

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        ack_t e;
        addr = a; wdata = d; mask = m; wr_en = 1'b1; rd_en = 1'b0;
        if (a[31:4] == BASE[31:4]) begin
            e.cyc = cyc + 1; e.chk = 1'b0; e.data = 32'd0; e.name = "write";
            ackq.push_back(e);
        end
        @(negedge clk);
        wr_en = 1'b0; mask = 4'd0; addr = 32'd0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        ack_t e;
        addr = a; rd_en = 1'b1; wr_en = 1'b0;
        e.cyc = cyc + 1; e.chk = 1'b1; e.data = exp; e.name = name;
        ackq.push_back(e);
        @(negedge clk);
        rd_en = 1'b0; addr = 32'd0;
    endtask

    task automatic read_status(input string name);
        bus_read(BASE + 32'h4, exp_status(cyc), name);
    endtask

    task automatic write_div(input logic [15:0] v, input logic [3:0] m);
        logic [15:0] nd = model_div[15:0];
        if (m[0]) nd[7:0]  = v[7:0];
        if (m[1]) nd[15:8] = v[15:8];
        model_div = (nd == 16'd0) ? 1 : int'(nd);
        bus_write(BASE + 32'h8, {16'h0, v}, m);
    endtask

    task automatic write_ctrl(input logic en);
        model_irq_en = en;
        bus_write(BASE + 32'hC, {31'h0, en}, 4'b0001);
    endtask

    task automatic push_byte(input logic [7:0] b, output int start);
        int  p = cyc;
        int  c = model_count(p);
        bit  pop_now = 0;
        fr_t f;
        foreach (sched[i]) if (sched[i].start == p + 1) pop_now = 1;
        start = -1;
        if (c == DEPTH && !pop_now) begin
            model_ovf = 1'b1;
        end else begin
            f.b = b; f.arrival = p + 1; f.div = model_div;
            f.start = (last_end > p + 2) ? last_end : p + 2;
            last_end = f.start + 10 * model_div;
            sched.push_back(f);
            rxq.push_back(f);
            start = f.start;
        end
        bus_write(BASE, {24'h0, b}, 4'b0001);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle();
        wait_until(last_end + 3);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("reset_tx_immediate", {31'h0, o_tx}, 32'h1);
        check("reset_ack", {31'h0, o_ack}, 32'h0);
        check("reset_data_out", o_data_out, 32'h0);
        check("reset_irq", {31'h0, o_irq}, 32'h0);
        sched.delete(); rxq.delete(); ackq.delete();
        model_div = 434; model_ovf = 1'b0; model_irq_en = 1'b0; last_end = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- ack / read-data monitor ----------------
    always @(negedge clk) begin
        ack_t e;
        if (!rst) begin
            if (o_ack) begin
                if (ackq.size() == 0) begin
                    check("unexpected_ack", {31'h0, o_ack}, 32'h0);
                end else begin
                    e = ackq.pop_front();
                    check({e.name, "_ack_cycle"}, cyc, e.cyc);
                    if (e.chk) check(e.name, o_data_out, e.data);
                end
            end else begin
                check("data_out_zero_without_ack", o_data_out, 32'h0);
                if (ackq.size() != 0 && ackq[0].cyc <= cyc) begin
                    e = ackq.pop_front();
                    check({e.name, "_missing_ack"}, cyc, e.cyc - 1);
                end
            end
        end
    end

    // ---------------- serial receiver monitor ----------------
    logic       rx_act = 1'b0;
    int         rx_t;
    int         rx_idx;
    int         rx_bad;
    fr_t        rx_cur;
    logic [9:0] rx_word;
    logic [9:0] rx_exp;

    always @(negedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act && o_tx === 1'b0) begin
            rx_act = 1'b1; rx_t = 0; rx_bad = 0; rx_word = 10'h0;
            if (rxq.size() == 0) begin
                check("unexpected_frame", cyc, 0);
                rx_cur.b = 8'h00; rx_cur.div = 1; rx_cur.start = cyc; rx_cur.arrival = cyc;
            end else begin
                rx_cur = rxq.pop_front();
                check("frame_start_cycle", cyc, rx_cur.start);
            end
            rx_exp = {1'b1, rx_cur.b, 1'b0};
        end
        if (!rst && rx_act) begin
            rx_idx = rx_t / rx_cur.div;
            if (o_tx !== rx_exp[rx_idx]) rx_bad++;
            if (rx_t % rx_cur.div == rx_cur.div / 2) rx_word[rx_idx] = o_tx;
            if (rx_t == 10 * rx_cur.div - 1) begin
                check("frame_byte", {24'h0, rx_word[8:1]}, {24'h0, rx_cur.b});
                check("frame_start_stop", {30'h0, rx_word[9], rx_word[0]}, 32'h2);
                check("frame_bit_glitches", rx_bad, 0);
                rx_act = 1'b0;
            end else begin
                rx_t++;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 100000", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s1, s2, s0, highs;
        logic [7:0] rb;

        // Power-on reset
        repeat (2) @(negedge clk);
        check("por_tx", {31'h0, o_tx}, 32'h1);
        check("por_ack", {31'h0, o_ack}, 32'h0);
        check("por_irq", {31'h0, o_irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        read_status("por_status");
        bus_read(BASE + 32'h8, 32'd434, "por_bauddiv");
        bus_read(BASE + 32'hC, 32'd0, "por_ctrl");
        bus_read(BASE + 32'h0, 32'd0, "txdata_read");

        // Single 0x55 frame at DIV=4
        write_div(16'd4, 4'b0011);
        push_byte(8'h55, s1);
        read_status("status_mid_frame");
        wait_idle();
        read_status("status_after_frame");

        // Two back-to-back frames at DIV=2
        write_div(16'd2, 4'b0011);
        push_byte(8'h41, s1);
        push_byte(8'h42, s2);
        check("b2b_frame_spacing", s2 - s1, 20);
        wait_idle();

        // Misses and masked-out TXDATA stores
        bus_write(BASE + 32'h10, 32'h99, 4'b0001);
        bus_write(BASE, 32'h77, 4'b0010);
        read_status("status_after_ignored_stores");
        repeat (30) @(negedge clk);

        // Interrupt level around a frame at DIV=3
        write_ctrl(1'b1);
        bus_read(BASE + 32'hC, 32'd1, "ctrl_readback");
        check("irq_idle_high", {31'h0, o_irq}, 32'h1);
        write_div(16'd3, 4'b0011);
        push_byte(8'h00, s0);
        wait_until(s0);
        highs = 0;
        while (cyc <= s0 + 30) begin
            if (o_irq !== 1'b0) highs++;
            @(negedge clk);
        end
        check("irq_low_during_frame", highs, 0);
        check("irq_rises_after_stop", {31'h0, o_irq}, 32'h1);
        write_ctrl(1'b0);

        // Divider sanitising and byte-lane writes
        write_div(16'd0, 4'b0011);
        bus_read(BASE + 32'h8, 32'd1, "bauddiv_zero_as_one");
        write_div(16'h0300, 4'b0010);
        bus_read(BASE + 32'h8, 32'h0301, "bauddiv_upper_lane");

        // Randomised bursts, divisors and status polls
        for (int it = 0; it < 8; it++) begin
            wait_idle();
            write_div(16'($urandom_range(1, 5)), 4'b0011);
            bus_read(BASE + 32'h8, model_div, "rand_bauddiv");
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                rb = 8'($urandom);
                push_byte(rb, s1);
                if ($urandom_range(0, 2) == 0) read_status("rand_status");
            end
            read_status("rand_status_burst_end");
            write_ctrl(1'($urandom));
            bus_read(BASE + 32'hC, {31'h0, model_irq_en}, "rand_ctrl");
        end
        wait_idle();
        read_status("rand_status_idle");
        write_ctrl(1'b0);

        // FIFO fill and overflow at DIV=1000
        write_div(16'd1000, 4'b0011);
        for (int k = 0; k < 17; k++) push_byte(8'(k + 8'h30), s1);
        read_status("status_full_no_ovf");
        push_byte(8'hEE, s1);
        check("overflow_byte_dropped", s1, -1);
        read_status("status_ovf_set");
        model_ovf = 1'b0;
        bus_write(BASE + 32'h4, 32'h8, 4'b0001);
        read_status("status_ovf_cleared");

        // Reset in the middle of the start bit of a long frame
        repeat (20) @(negedge clk);
        check("tx_low_before_reset", {31'h0, o_tx}, 32'h0);
        do_reset();
        read_status("status_after_midframe_reset");
        bus_read(BASE + 32'h8, 32'd434, "bauddiv_after_reset");
        write_div(16'd3, 4'b0011);
        push_byte(8'hA5, s1);
        wait_idle();
        read_status("status_final");

        repeat (5) @(negedge clk);
        check("frames_outstanding", rxq.size(), 0);
        check("acks_outstanding", ackq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
